// File: rtl/vm_pkg.sv
// Shared types and helpers for the multi-item vending controller:
// FSM state encoding, coin codes and per-item price extraction.
package vm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    COLLECT = 2'b01,
    VEND    = 2'b10,
    REFUND  = 2'b11
  } state_t;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_1    = 2'b01;
  localparam logic [1:0] COIN_2    = 2'b10;
  localparam logic [1:0] COIN_3    = 2'b11;

  localparam int unsigned PRICE_VEC_W = 256;

  // Returns item idx's price from a packed price vector (width bits per item).
  function automatic logic [31:0] price_slice(input logic [PRICE_VEC_W-1:0] prices,
                                              input int unsigned idx,
                                              input int unsigned width);
    logic [31:0] mask;
    mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    return 32'(prices >> (idx * width)) & mask;
  endfunction

endpackage

// File: rtl/vm_stock_counter.sv
// Per-item stock counter: decrement on sale, saturating increment on restock;
// a simultaneous sale and restock leaves the count unchanged.
module vm_stock_counter
  import vm_pkg::*;
#(
  parameter int unsigned STOCK_W    = 4,
  parameter int unsigned INIT_STOCK = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inc,
  input  logic               dec,
  output logic [STOCK_W-1:0] count,
  output logic               empty
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= STOCK_W'(INIT_STOCK);
    end else if (inc && !dec) begin
      if (count != '1) count <= count + STOCK_W'(1);
    end else if (dec && !inc) begin
      if (count != '0) count <= count - STOCK_W'(1);
    end
  end

  assign empty = (count == '0);

endmodule

// File: rtl/vending_machine_multi.sv
// Multi-item vending controller: coin decode, credit register, purchase/refund
// FSM and one stock counter per item. Change is returned as unit pulses.
module vending_machine_multi
  import vm_pkg::*;
#(
  parameter int unsigned NUM_ITEMS   = 4,
  parameter int unsigned CREDIT_W    = 8,
  parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES = {8'd100, 8'd75, 8'd50, 8'd25},
  parameter int unsigned COIN1_VAL   = 5,
  parameter int unsigned COIN2_VAL   = 10,
  parameter int unsigned COIN3_VAL   = 25,
  parameter int unsigned CHANGE_UNIT = 5,
  parameter int unsigned MAX_CREDIT  = 200,
  parameter int unsigned STOCK_W     = 4,
  parameter int unsigned INIT_STOCK  = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [1:0]                   money,
  input  logic                         sel_valid,
  input  logic [$clog2(NUM_ITEMS)-1:0] sel,
  input  logic                         cancel,
  input  logic                         restock,
  input  logic [$clog2(NUM_ITEMS)-1:0] restock_item,
  output logic                         dispense,
  output logic [$clog2(NUM_ITEMS)-1:0] dispense_item,
  output logic                         change,
  output logic [CREDIT_W-1:0]          credit,
  output logic                         sold_out,
  output logic                         coin_reject,
  output logic [1:0]                   current_state
);

  localparam int unsigned SEL_W = $clog2(NUM_ITEMS);
  localparam logic [CREDIT_W-1:0] UNIT = CREDIT_W'(CHANGE_UNIT);

  state_t               state, state_n;
  logic [CREDIT_W-1:0]  credit_n;
  logic [SEL_W-1:0]     item_n;
  logic                 reject_n, sold_out_n;
  logic                 cancel_acc, sel_acc;
  logic [CREDIT_W-1:0]  coin_val, price;
  logic                 coin_in, coin_fits;
  logic [NUM_ITEMS-1:0] sale, empty;

  always_comb begin
    coin_val = '0;
    case (money)
      COIN_1:  coin_val = CREDIT_W'(COIN1_VAL);
      COIN_2:  coin_val = CREDIT_W'(COIN2_VAL);
      COIN_3:  coin_val = CREDIT_W'(COIN3_VAL);
      default: coin_val = '0;
    endcase
  end

  assign coin_in   = (money != COIN_NONE);
  assign coin_fits = ({1'b0, credit} + {1'b0, coin_val}) <= (CREDIT_W+1)'(MAX_CREDIT);
  assign price     = CREDIT_W'(price_slice(PRICE_VEC_W'(PRICES), 32'(sel), CREDIT_W));

  // Selection is resolved before the coin so a coin sharing the cycle with an
  // accepted cancel/selection is refused, while an ignored selection lets it in.
  always_comb begin
    state_n    = state;
    credit_n   = credit;
    item_n     = '0;
    reject_n   = 1'b0;
    sold_out_n = 1'b0;
    cancel_acc = 1'b0;
    sel_acc    = 1'b0;
    sale       = '0;
    case (state)
      IDLE, COLLECT: begin
        cancel_acc = cancel && (state == COLLECT);
        if (cancel_acc) begin
          state_n = REFUND;
        end else if (sel_valid) begin
          if (empty[sel]) begin
            sold_out_n = 1'b1;
          end else if (credit >= price) begin
            sel_acc     = 1'b1;
            state_n     = VEND;
            credit_n    = credit - price;
            item_n      = sel;
            sale[sel]   = 1'b1;
          end
        end
        if (coin_in) begin
          if (cancel_acc || sel_acc || !coin_fits) begin
            reject_n = 1'b1;
          end else begin
            credit_n = credit + coin_val;
            state_n  = COLLECT;
          end
        end
      end
      VEND: begin
        reject_n = coin_in;
        state_n  = (credit != '0) ? REFUND : IDLE;
      end
      REFUND: begin
        reject_n = coin_in;
        if (credit <= UNIT) begin
          credit_n = '0;
          state_n  = IDLE;
        end else begin
          credit_n = credit - UNIT;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      credit        <= '0;
      dispense_item <= '0;
      coin_reject   <= 1'b0;
      sold_out      <= 1'b0;
    end else begin
      state         <= state_n;
      credit        <= credit_n;
      dispense_item <= item_n;
      coin_reject   <= reject_n;
      sold_out      <= sold_out_n;
    end
  end

  assign dispense      = (state == VEND);
  assign change        = (state == REFUND);
  assign current_state = state;

  for (genvar i = 0; i < NUM_ITEMS; i++) begin : g_item
    vm_stock_counter #(
      .STOCK_W    (STOCK_W),
      .INIT_STOCK (INIT_STOCK)
    ) u_stock (
      .clk   (clk),
      .rst   (rst),
      .inc   (restock && (restock_item == SEL_W'(i))),
      .dec   (sale[i]),
      .count (),
      .empty (empty[i])
    );
  end

endmodule

// File: tb/tb_vending_machine_multi.sv
// Directed self-checking bench for vending_machine_multi (default parameters).
module tb_vending_machine_multi;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] money = '0;
  logic       sel_valid = 1'b0;
  logic [1:0] sel = '0;
  logic       cancel = 1'b0;
  logic       restock = 1'b0;
  logic [1:0] restock_item = '0;
  logic       dispense;
  logic [1:0] dispense_item;
  logic       change;
  logic [7:0] credit;
  logic       sold_out;
  logic       coin_reject;
  logic [1:0] current_state;

  int n_checks = 0;
  int n_fails  = 0;

  vending_machine_multi dut (
    .clk           (clk),
    .rst           (rst),
    .money         (money),
    .sel_valid     (sel_valid),
    .sel           (sel),
    .cancel        (cancel),
    .restock       (restock),
    .restock_item  (restock_item),
    .dispense      (dispense),
    .dispense_item (dispense_item),
    .change        (change),
    .credit        (credit),
    .sold_out      (sold_out),
    .coin_reject   (coin_reject),
    .current_state (current_state)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] m, input logic sv, input logic [1:0] s,
                       input logic c, input logic r, input logic [1:0] ri);
    money = m; sel_valid = sv; sel = s; cancel = c; restock = r; restock_item = ri;
    @(posedge clk);
    #1;
    money = '0; sel_valid = 1'b0; cancel = 1'b0; restock = 1'b0;
  endtask

  task automatic idle_cycle();
    drive(2'b00, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0);
  endtask

  task automatic coin(input logic [1:0] m);
    drive(m, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle_cycle();
    rst = 1'b1;
  endtask

  task automatic chk_stock(input int e0, input int e1, input int e2, input int e3);
    chk("stock0", 32'(dut.g_item[0].u_stock.count), e0);
    chk("stock1", 32'(dut.g_item[1].u_stock.count), e1);
    chk("stock2", 32'(dut.g_item[2].u_stock.count), e2);
    chk("stock3", 32'(dut.g_item[3].u_stock.count), e3);
  endtask

  initial begin
    int cnt;

    // Reset state
    do_reset();
    chk("rst_state", 32'(current_state), 0);
    chk("rst_credit", 32'(credit), 0);
    chk("rst_dispense", 32'(dispense), 0);
    chk("rst_item", 32'(dispense_item), 0);
    chk("rst_change", 32'(change), 0);
    chk("rst_sold_out", 32'(sold_out), 0);
    chk("rst_reject", 32'(coin_reject), 0);
    chk_stock(2, 2, 2, 2);

    // 10+10+10, buy item 0 (25): one change pulse
    coin(2'b10);
    chk("c1_credit", 32'(credit), 10);
    chk("c1_state", 32'(current_state), 1);
    coin(2'b10);
    coin(2'b10);
    chk("c3_credit", 32'(credit), 30);
    drive(2'b00, 1'b1, 2'd0, 1'b0, 1'b0, 2'd0);
    chk("buy_state", 32'(current_state), 2);
    chk("buy_dispense", 32'(dispense), 1);
    chk("buy_item", 32'(dispense_item), 0);
    chk("buy_credit", 32'(credit), 5);
    chk("buy_change_lat", 32'(change), 0);
    idle_cycle();
    chk("chg_pulse", 32'(change), 1);
    chk("chg_dispense", 32'(dispense), 0);
    chk("chg_state", 32'(current_state), 3);
    idle_cycle();
    chk("chg_done", 32'(change), 0);
    chk("chg_credit", 32'(credit), 0);
    chk("chg_state_idle", 32'(current_state), 0);

    // Two exact buys empty item 0, third selection is sold out
    do_reset();
    for (int k = 0; k < 2; k++) begin
      coin(2'b11);
      drive(2'b00, 1'b1, 2'd0, 1'b0, 1'b0, 2'd0);
      chk("exact_dispense", 32'(dispense), 1);
      chk("exact_credit", 32'(credit), 0);
      idle_cycle();
      chk("exact_idle", 32'(current_state), 0);
    end
    chk("stock0_empty", 32'(dut.g_item[0].u_stock.count), 0);
    coin(2'b11);
    drive(2'b00, 1'b1, 2'd0, 1'b0, 1'b0, 2'd0);
    chk("so_pulse", 32'(sold_out), 1);
    chk("so_credit", 32'(credit), 25);
    chk("so_state", 32'(current_state), 1);
    chk("so_dispense", 32'(dispense), 0);
    coin(2'b10);
    chk("so_clear", 32'(sold_out), 0);
    chk("pre_cancel_credit", 32'(credit), 35);

    // Cancel with 35: seven consecutive change pulses
    drive(2'b00, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0);
    cnt = 0;
    while (change === 1'b1 && cnt < 20) begin
      cnt++;
      idle_cycle();
    end
    chk("refund_pulses", cnt, 7);
    chk("refund_state", 32'(current_state), 0);
    chk("refund_credit", 32'(credit), 0);

    // Credit ceiling
    do_reset();
    for (int k = 0; k < 7; k++) coin(2'b11);
    coin(2'b10);
    coin(2'b01);
    chk("ceil_190", 32'(credit), 190);
    coin(2'b11);
    chk("ceil_reject", 32'(coin_reject), 1);
    chk("ceil_hold", 32'(credit), 190);
    chk("ceil_state", 32'(current_state), 1);
    coin(2'b10);
    chk("ceil_200", 32'(credit), 200);
    chk("ceil_reject_clr", 32'(coin_reject), 0);

    // Sale + restock of item 1 + coin in the same cycle
    do_reset();
    coin(2'b11);
    coin(2'b11);
    chk("sr_credit", 32'(credit), 50);
    drive(2'b01, 1'b1, 2'd1, 1'b0, 1'b1, 2'd1);
    chk("sr_dispense", 32'(dispense), 1);
    chk("sr_item", 32'(dispense_item), 1);
    chk("sr_reject", 32'(coin_reject), 1);
    chk("sr_credit0", 32'(credit), 0);
    chk("sr_stock1", 32'(dut.g_item[1].u_stock.count), 2);
    idle_cycle();
    chk("sr_idle", 32'(current_state), 0);
    chk("sr_item_clr", 32'(dispense_item), 0);
    chk("sr_reject_clr", 32'(coin_reject), 0);

    // Unaffordable selection does not block a coin; restock saturation
    do_reset();
    coin(2'b11);
    drive(2'b10, 1'b1, 2'd2, 1'b0, 1'b0, 2'd0);
    chk("ign_credit", 32'(credit), 35);
    chk("ign_state", 32'(current_state), 1);
    chk("ign_reject", 32'(coin_reject), 0);
    chk("ign_sold_out", 32'(sold_out), 0);
    for (int k = 0; k < 14; k++) drive(2'b00, 1'b0, 2'd0, 1'b0, 1'b1, 2'd3);
    chk("sat_stock3", 32'(dut.g_item[3].u_stock.count), 15);

    // Reset on the 2nd REFUND cycle
    drive(2'b00, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0);
    chk("r1_change", 32'(change), 1);
    idle_cycle();
    chk("r2_change", 32'(change), 1);
    chk("r2_credit", 32'(credit), 30);
    rst = 1'b0;
    idle_cycle();
    rst = 1'b1;
    chk("mid_rst_state", 32'(current_state), 0);
    chk("mid_rst_credit", 32'(credit), 0);
    chk("mid_rst_change", 32'(change), 0);
    chk_stock(2, 2, 2, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
